// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU front end.
package cpu_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   // Instructions are halfword aligned, so bit 0 of any target is discarded.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or insert a bubble.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               bubble,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [PC_W-1:0]    ifid_pc_plus2,
   output logic               ifid_valid
);

   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    pc_plus2_q;
   logic               valid_q;

   // A bubble clears the instruction but keeps the last PC pair for debug visibility.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= 16'h0000;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else if (bubble) begin
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (load) begin
         instr_q    <= instr_in;
         pc_q       <= pc_in;
         pc_plus2_q <= pc_in + 16'h0002;
         valid_q    <= 1'b1;
      end else begin
         instr_q    <= instr_q;
         pc_q       <= pc_q;
         pc_plus2_q <= pc_plus2_q;
         valid_q    <= valid_q;
      end
   end

   assign ifid_instr    = instr_q;
   assign ifid_pc       = pc_q;
   assign ifid_pc_plus2 = pc_plus2_q;
   assign ifid_valid    = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC sequencing, redirects, stall hold and out-of-range fault.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          PC_LIMIT = 32,
   parameter int          PC_STEP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic [15:0] fetch_pc,
   input  logic [15:0] mem_instr,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        fault,
   output logic [15:0] fault_pc,
   output logic [15:0] fetch_count
);

   localparam logic [PC_W-1:0] LIMIT_W = PC_W'(PC_LIMIT);
   localparam logic [PC_W-1:0] STEP_W  = PC_W'(PC_STEP);

   fetch_state_t    state_q;
   logic [PC_W-1:0] pc_q;
   logic            fault_q;
   logic [PC_W-1:0] fault_pc_q;
   logic [15:0]     count_q;

   logic            in_range_s;
   logic            load_s;
   logic            bubble_s;

   assign in_range_s = (pc_q < LIMIT_W);

   // IF/ID control; a FAULT cycle keeps re-issuing bubbles regardless of stall.
   always_comb begin
      load_s   = 1'b0;
      bubble_s = 1'b0;
      if (redirect_valid) begin
         bubble_s = 1'b1;
      end else if (state_q == FAULT) begin
         bubble_s = 1'b1;
      end else if (stall) begin
         bubble_s = 1'b0;
      end else if (in_range_s) begin
         load_s = 1'b1;
      end else begin
         bubble_s = 1'b1;
      end
   end

   // Fetch FSM: redirect beats stall, and only a redirect leaves FAULT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= 16'h0000;
         count_q    <= 16'h0000;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect_valid) begin
                  pc_q <= align_pc(redirect_pc);
               end else if (stall) begin
                  pc_q <= pc_q;
               end else if (in_range_s) begin
                  pc_q    <= pc_q + STEP_W;
                  count_q <= (count_q == 16'hFFFF) ? count_q : count_q + 16'h0001;
               end else begin
                  fault_q    <= 1'b1;
                  fault_pc_q <= pc_q;
                  state_q    <= FAULT;
               end
            end
            FAULT: begin
               if (redirect_valid) begin
                  pc_q    <= align_pc(redirect_pc);
                  fault_q <= 1'b0;
                  state_q <= RUN;
               end else begin
                  pc_q <= pc_q;
               end
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk          (clk),
      .reset        (reset),
      .load         (load_s),
      .bubble       (bubble_s),
      .instr_in     (mem_instr),
      .pc_in        (pc_q),
      .ifid_instr   (ifid_instr),
      .ifid_pc      (ifid_pc),
      .ifid_pc_plus2(ifid_pc_plus2),
      .ifid_valid   (ifid_valid)
   );

   assign fetch_pc    = pc_q;
   assign fault       = fault_q;
   assign fault_pc    = fault_pc_q;
   assign fetch_count = count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch (IF) stage that drives the instruction memory's 16-bit pc input and consumes the instruction it returns in the same cycle. It holds the program counter and handles sequential advance, stall hold and redirects from branch/jump resolution. It loads the IF/ID pipeline register that feeds decode. It also raises a fault when the PC leaves the populated instruction address window.

Parameters:
RESET_PC, 16'h0000, byte address fetched first after reset
PC_LIMIT, 32, byte address bound; fetch_pc >= PC_LIMIT is out of range (memory holds 16 words)
PC_STEP, 2, byte increment per sequential fetch (16-bit instructions)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard hold from decode; freezes PC and IF/ID
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_pc  input  16  byte target of redirect
fetch_pc  output  16  address to instruction memory pc input; equals internal pc_reg
mem_instr  input  16  instruction returned by memory for fetch_pc (combinational, same cycle)
ifid_instr  output  16  IF/ID instruction
ifid_pc  output  16  IF/ID byte address of ifid_instr
ifid_pc_plus2  output  16  ifid_pc + 2, mod 2^16
ifid_valid  output  1  IF/ID holds a real instruction; 0 = bubble
fault  output  1  sticky out-of-range fetch indicator
fault_pc  output  16  PC that caused the fault
fetch_count  output  16  count of valid IF/ID loads, saturating

Behaviour:
- Reset (sync): pc_reg=RESET_PC, ifid_instr=16'h0000, ifid_pc=0, ifid_pc_plus2=0, ifid_valid=0, fault=0, fault_pc=0, fetch_count=0, state=RUN. Reset has priority over every other input, including mid-stall and in FAULT.
- fetch_pc = pc_reg combinationally. No added latency: the word fetched in cycle N appears on IF/ID after edge N.
- States: RUN, FAULT. Priority within a cycle: reset > redirect_valid > stall > normal.
- RUN, redirect_valid=1:
  - pc_reg <= {redirect_pc[15:1],1'b0}; odd targets have bit 0 forced to 0.
  - IF/ID gets a bubble: ifid_valid=0, ifid_instr=0; ifid_pc and ifid_pc_plus2 hold.
  - Applies even when stall=1.
  - Exactly one bubble cycle per redirect.
- RUN, stall=1, no redirect: pc_reg and all IF/ID fields hold; no fault evaluation; count holds.
- RUN, normal, pc_reg < PC_LIMIT:
  - ifid_instr<=mem_instr, ifid_pc<=pc_reg, ifid_pc_plus2<=pc_reg+2, ifid_valid<=1.
  - pc_reg<=pc_reg+PC_STEP, 16-bit wrap.
  - fetch_count+1, saturating at 16'hFFFF.
- RUN, normal, pc_reg >= PC_LIMIT:
  - fault<=1, fault_pc<=pc_reg, ifid_valid<=0, ifid_instr<=0.
  - pc_reg holds; state<=FAULT.
- FAULT:
  - pc_reg holds; IF/ID stays bubble; stall is ignored.
  - redirect_valid loads pc_reg as in RUN, clears fault (fault_pc retained), state<=RUN.
  - A redirect to an out-of-range target re-faults on the next normal cycle.
- Wrap at 16'hFFFE -> 16'h0000 cannot occur with PC_LIMIT <= 16'hFFFE; the fault triggers first.

Decomposition:
- Shared package cpu_pkg:
  - PC_W=16, INSTR_W=16
  - NOP_INSTR=16'h0000
  - fetch_state_t enum {RUN, FAULT}
- Sub-module if_id_reg: IF/ID register with load/hold/bubble controls. The PC and FSM logic stay in instr_fetch_unit.

Test Plan:
1. Memory model rom[0]=16'hE480, rom[1]=16'hE90A, no stall; release reset -> fetch_pc=0; after edge 1: ifid_instr=E480, ifid_pc=0, ifid_pc_plus2=2, ifid_valid=1, fetch_pc=2; after edge 2: ifid_instr=E90A, fetch_count=2.
2. stall=1 for 3 cycles while fetch_pc=4 -> fetch_pc stays 4, IF/ID and fetch_count unchanged; deassert -> next edge loads rom[2] with ifid_pc=4.
3. At fetch_pc=0x0E, pulse redirect_valid with redirect_pc=0x0006 and stall=1 -> next edge: ifid_valid=0, ifid_instr=0, fetch_pc=6; following edge: ifid_instr=rom[3]=F201, ifid_pc=6.
4. Run sequentially -> pc 0x1E fetched valid; at fetch_pc=0x20: fault=1, fault_pc=0x0020, ifid_valid=0, fetch_pc holds 0x20 for 5+ cycles with stall toggling; redirect to 0x14 -> fault=0; next edge ifid_instr=rom[10]=F207.
5. redirect_pc=0x0007 -> fetch_pc=0x0006; redirect_pc=0x0040 -> one bubble, then fault=1, fault_pc=0x0040.
6. Assert reset during stall and again during FAULT -> at that edge all outputs return to reset values, fetch_pc=RESET_PC, state RUN.
